pulse_period_meter: RTL

PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

---
 rtl/pulse_period_meter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pulse_period_meter.sv
// -----------------------------------------------------------------------------
// pulse_period_meter
//
// Measures the number of clk cycles between consecutive rising edges of
// pulse_in. The first edge after enabling only arms the block. Every edge
// after that terminates one period and loads the result into a
// valid/ready output register.
//
// Ports
//   clk           : single clock, rising edge
//   rst           : synchronous, active-high reset
//   enable        : measurement enable; low discards any partial count
//   pulse_in      : pulse train already synchronous to clk
//   period_out    : last measured period in clk cycles (Width bits)
//   period_valid  : period_out holds a result not yet accepted
//   period_ready  : consumer accepts the result
//   period_ovf    : the held result saturated at 2^Width-1
//   lost          : sticky; a result was overwritten before acceptance
// -----------------------------------------------------------------------------
module pulse_period_meter #(
  parameter int Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pulse_in,
  output logic [Width-1:0] period_out,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             period_ovf,
  output logic             lost
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [Width-1:0] CntMax = '1;
  localparam logic [Width-1:0] CntOne = Width'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_prev_in;
  logic             w_edge;
  logic [Width-1:0] r_cnt;
  logic [Width-1:0] w_cnt_nxt;
  logic             r_sat;
  logic             w_sat_nxt;
  logic             w_load;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [Width-1:0] sat_inc(input logic [Width-1:0] v);
    if (v == CntMax) begin
      return CntMax;
    end
    return v + CntOne;
  endfunction

  // prev_in is tracked even while disabled, so enabling with pulse_in
  // already high does not look like a rising edge.
  assign w_edge = pulse_in & ~r_prev_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_in <= 1'b0;
    end else begin
      r_prev_in <= pulse_in;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sat_nxt   = r_sat;
    w_load      = 1'b0;
    if (!enable) begin
      // Dropping enable abandons the partial period from any state.
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_sat_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt_nxt   = '0;
          w_sat_nxt   = 1'b0;
          w_state_nxt = ARM;
        end
        ARM: begin
          if (w_edge) begin
            w_cnt_nxt   = CntOne;
            w_sat_nxt   = 1'b0;
            w_state_nxt = MEASURE;
          end
        end
        MEASURE: begin
          if (w_edge) begin
            // The edge cycle itself is the first cycle of the next period.
            w_load    = 1'b1;
            w_cnt_nxt = CntOne;
            w_sat_nxt = 1'b0;
          end else begin
            // sat marks that an increment was actually clamped.
            if (r_cnt == CntMax) begin
              w_sat_nxt = 1'b1;
            end
            w_cnt_nxt = sat_inc(r_cnt);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_sat_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sat   <= w_sat_nxt;
    end
  end

  // Result register. A new load wins over an accept in the same cycle, and
  // only a load onto an unaccepted result raises the sticky lost flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_out   <= '0;
      period_ovf   <= 1'b0;
      period_valid <= 1'b0;
      lost         <= 1'b0;
    end else if (w_load) begin
      period_out   <= r_cnt;
      period_ovf   <= r_sat;
      period_valid <= 1'b1;
      if (period_valid && !period_ready) begin
        lost <= 1'b1;
      end
    end else if (period_valid && period_ready) begin
      period_valid <= 1'b0;
    end
  end

endmodule
